// File: rtl/rt_mem_loader.sv
// Boot loader for racetrack memory port B: streams source words into consecutive word
// addresses, waits for each write completion, then hands port B to the core for fetch.
module rt_mem_loader #(
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned FUNCT_WIDTH = 3,
  parameter int unsigned RV_TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [15:0]            num_words_i,
  input  logic                   src_valid_i,
  input  logic [31:0]            src_data_i,
  output logic                   src_ready_o,
  input  logic                   core_en_i,
  input  logic                   core_we_i,
  input  logic [ADDR_WIDTH-1:0]  core_addr_i,
  input  logic [31:0]            core_wdata_i,
  input  logic [3:0]             core_be_i,
  input  logic [FUNCT_WIDTH-1:0] core_funct_i,
  output logic                   core_rvalid_o,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  output logic [3:0]             mem_be_o,
  output logic [FUNCT_WIDTH-1:0] mem_funct_o,
  input  logic                   mem_rvalid_i,
  output logic                   busy_o,
  output logic                   fetch_enable_o,
  output logic                   error_o
);

  localparam int unsigned CntW = $clog2(RV_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StIssue, StWaitRv, StGap, StDone, StError
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           idx_q, idx_d;
  logic [15:0]           num_q, num_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           data_q, data_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // Word address wraps modulo 2^ADDR_WIDTH by truncation.
  assign wr_addr = base_q + ADDR_WIDTH'({idx_q, 2'b00});

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      num_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      base_q  <= base_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt_q counts cycles elapsed since the ISSUE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    base_d  = base_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = base_addr_i;
          num_d   = num_words_i;
          idx_d   = '0;
          state_d = (num_words_i != 16'd0) ? StFetch : StDone;
        end
      end
      StFetch: begin
        if (src_valid_i) begin
          data_d  = src_data_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CntW'(1);
        state_d = StWaitRv;
      end
      StWaitRv: begin
        if (mem_rvalid_i) begin
          state_d = StGap;
        end else if (cnt_q >= CntW'(RV_TIMEOUT - 1)) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_q + 16'd1 == num_q) ? StDone : StFetch;
      end
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; port B belongs to the loader until DONE, then to the core.
  always_comb begin
    src_ready_o    = 1'b0;
    core_rvalid_o  = 1'b0;
    mem_en_o       = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_be_o       = '0;
    mem_funct_o    = '0;
    busy_o         = 1'b0;
    fetch_enable_o = 1'b0;
    error_o        = 1'b0;
    unique case (state_q)
      StFetch: begin
        src_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      StIssue: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = 4'hF;
        mem_addr_o  = wr_addr;
        mem_wdata_o = data_q;
        busy_o      = 1'b1;
      end
      StWaitRv: begin
        mem_addr_o  = wr_addr;
        mem_wdata_o = data_q;
        busy_o      = 1'b1;
      end
      StGap: busy_o = 1'b1;
      StDone: begin
        fetch_enable_o = 1'b1;
        mem_en_o       = core_en_i;
        mem_we_o       = core_we_i;
        mem_addr_o     = core_addr_i;
        mem_wdata_o    = core_wdata_i;
        mem_be_o       = core_be_i;
        mem_funct_o    = core_funct_i;
        core_rvalid_o  = mem_rvalid_i;
      end
      StError: error_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rt_mem_loader.sv
// Randomized self-checking bench for rt_mem_loader against a transaction-level model.
module tb_rt_mem_loader;

  localparam int unsigned AW  = 22;
  localparam int unsigned FW  = 3;
  localparam int unsigned TMO = 16;
  localparam int          AMASK = (1 << AW) - 1;

  logic          clk, rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [15:0]   num_words_i;
  logic          src_valid_i;
  logic [31:0]   src_data_i;
  logic          src_ready_o;
  logic          core_en_i, core_we_i;
  logic [AW-1:0] core_addr_i;
  logic [31:0]   core_wdata_i;
  logic [3:0]    core_be_i;
  logic [FW-1:0] core_funct_i;
  logic          core_rvalid_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic [FW-1:0] mem_funct_o;
  logic          mem_rvalid_i;
  logic          busy_o, fetch_enable_o, error_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] words [64];
  int          res_wcnt, res_lat, res_err_dist;

  rt_mem_loader #(
    .ADDR_WIDTH (AW),
    .FUNCT_WIDTH(FW),
    .RV_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_words_i   (num_words_i),
    .src_valid_i   (src_valid_i),
    .src_data_i    (src_data_i),
    .src_ready_o   (src_ready_o),
    .core_en_i     (core_en_i),
    .core_we_i     (core_we_i),
    .core_addr_i   (core_addr_i),
    .core_wdata_i  (core_wdata_i),
    .core_be_i     (core_be_i),
    .core_funct_i  (core_funct_i),
    .core_rvalid_o (core_rvalid_o),
    .mem_en_o      (mem_en_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .mem_funct_o   (mem_funct_o),
    .mem_rvalid_i  (mem_rvalid_i),
    .busy_o        (busy_o),
    .fetch_enable_o(fetch_enable_o),
    .error_o       (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {src_ready_o, core_rvalid_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
            mem_be_o, mem_funct_o, busy_o, fetch_enable_o, error_o};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start_i = 1'b0; src_valid_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one load with random rvalid delays in [dmin,dmax] (never when no_rv) and source
  // gaps with probability gap_pct; checks every write against base + 4*i and words[i].
  task automatic do_load(input logic [AW-1:0] base, input int num, input int dmin,
                         input int dmax, input int gap_pct, input bit no_rv);
    int cyc, k, wcnt, gaps, sum, wt, issue_cyc;
    bit pend;
    logic [AW-1:0] ea;
    k = 0; wcnt = 0; gaps = 0; sum = 0; wt = 0; pend = 0; issue_cyc = 0;
    @(negedge clk);
    start_i = 1'b1; base_addr_i = base; num_words_i = 16'(num);
    @(negedge clk);
    start_i = 1'b0;
    base_addr_i = AW'($urandom); num_words_i = 16'($urandom);
    cyc = 1;
    while (!fetch_enable_o && !error_o && cyc < 3000) begin
      mem_rvalid_i = 1'b0;
      if (pend) begin
        wt--;
        if (wt == 0) begin mem_rvalid_i = 1'b1; pend = 0; end
      end
      if (mem_en_o) begin
        ea = AW'((int'(base) + 4 * wcnt) & AMASK);
        check("wr_addr", mem_addr_o, ea);
        check("wr_data", mem_wdata_o, words[wcnt]);
        check("wr_ctl", {mem_we_o, mem_be_o, mem_funct_o}, {1'b1, 4'hF, 3'd0});
        wcnt++;
        issue_cyc = cyc;
        if (!no_rv) begin
          pend = 1;
          wt = $urandom_range(dmax, dmin);
          sum += 3 + wt;
        end
      end else begin
        check("idle_we", mem_we_o, 1'b0);
      end
      check("busy", busy_o, 1'b1);
      check("core_rv_blk", core_rvalid_o, 1'b0);
      src_valid_i = 1'b0;
      if (src_ready_o) begin
        if (int'($urandom_range(99)) < gap_pct) gaps++;
        else begin src_valid_i = 1'b1; src_data_i = words[k]; k++; end
      end
      core_en_i = 1'b1; core_we_i = 1'b1; core_addr_i = AW'($urandom);
      core_wdata_i = $urandom; core_be_i = 4'($urandom); core_funct_i = FW'($urandom);
      @(negedge clk);
      cyc++;
    end
    mem_rvalid_i = 1'b0; src_valid_i = 1'b0;
    if (cyc >= 3000) check("cycle_budget", 1'b0, 1'b1);
    res_wcnt = wcnt;
    res_lat = cyc - 1;
    res_err_dist = cyc - issue_cyc;
    if (!no_rv) begin
      check("wr_count", wcnt, num);
      check("latency", res_lat, sum + gaps);
      check("done_flags", {fetch_enable_o, busy_o, error_o}, 3'b100);
    end
  endtask

  // Port B passthrough in DONE, and start ignored there.
  task automatic done_checks();
    for (int i = 0; i < 3; i++) begin
      core_en_i = 1'($urandom); core_we_i = 1'($urandom); core_addr_i = AW'($urandom);
      core_wdata_i = $urandom; core_be_i = 4'($urandom); core_funct_i = FW'($urandom);
      mem_rvalid_i = 1'($urandom);
      #1;
      check("pass_ctl", {mem_en_o, mem_we_o, mem_be_o, mem_funct_o, core_rvalid_o},
            {core_en_i, core_we_i, core_be_i, core_funct_i, mem_rvalid_i});
      check("pass_addr", mem_addr_o, core_addr_i);
      check("pass_data", mem_wdata_o, core_wdata_i);
      @(negedge clk);
    end
    start_i = 1'b1; num_words_i = 16'd5;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("start_ignored", {fetch_enable_o, busy_o, src_ready_o}, 3'b100);
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    int n;
    logic [AW-1:0] b;
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    src_valid_i = 1'b0; src_data_i = '0; mem_rvalid_i = 1'b0;
    core_en_i = 1'b1; core_we_i = 1'b1; core_addr_i = 22'h40; core_wdata_i = 32'hDEAD;
    core_be_i = 4'hF; core_funct_i = 3'd5;
    #12;
    check("reset_outs", all_outs(), 96'd0);
    do_reset();
    check("idle_outs", all_outs(), 96'd0);

    // Directed: three words, rvalid two cycles after each ISSUE.
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    do_load(22'h0, 3, 2, 2, 0, 1'b0);
    check("lat15", res_lat, 15);
    core_en_i = 1'b1; core_addr_i = 22'h40;
    #1;
    check("core_addr_40", mem_addr_o, 22'h40);
    @(negedge clk);
    done_checks();

    // Zero-length load goes straight to DONE with no write.
    do_reset();
    do_load(22'h100, 0, 1, 1, 0, 1'b0);
    check("zero_lat", res_lat, 0);
    done_checks();

    // Address wrap at the top of the space.
    do_reset();
    words[0] = $urandom; words[1] = $urandom;
    do_load(22'h3FFFFC, 2, 1, 3, 0, 1'b0);
    done_checks();

    // Random loads with source gaps and varied completion delay.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = $urandom_range(8, 1);
      b = AW'({$urandom} & 32'hFFFF_FFFC);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      do_load(b, n, 1, 6, 40, 1'b0);
      done_checks();
    end

    // Completion never returned: ERROR exactly TMO cycles after ISSUE.
    do_reset();
    words[0] = $urandom; words[1] = $urandom;
    do_load(22'h200, 2, 1, 1, 0, 1'b1);
    check("err_dist", res_err_dist, TMO);
    check("err_wcnt", res_wcnt, 1);
    check("err_flags", {error_o, fetch_enable_o, busy_o, mem_en_o}, 4'b1000);
    repeat (3) @(negedge clk);
    check("err_hold", {error_o, fetch_enable_o}, 2'b10);

    // Asynchronous reset while waiting for completion.
    do_reset();
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 22'h80; num_words_i = 16'd4;
    @(negedge clk);
    start_i = 1'b0; src_valid_i = 1'b1; src_data_i = 32'hA5A5A5A5;
    n = 0;
    while (!mem_en_o && n < 20) begin @(negedge clk); n++; end
    check("abort_issue_seen", mem_en_o, 1'b1);
    src_valid_i = 1'b0;
    @(negedge clk);
    check("abort_in_wait", {busy_o, mem_en_o, mem_addr_o}, {1'b1, 1'b0, 22'h80});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_async", all_outs(), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_restart", all_outs(), 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rt_mem_loader.md
RT_MEM_LOADER -- requirements
Module: rt_mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 22: byte-address width of memory port B.
REQ-002 Parameter FUNCT_WIDTH, default 3: width of the LiM function code.
REQ-003 Parameter RV_TIMEOUT, default 64: maximum cycles to wait for mem_rvalid_i per write.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  one-cycle load request, sampled only in IDLE.
REQ-007 base_addr_i  in  ADDR_WIDTH  first byte address, word-aligned; captured on start.
REQ-008 num_words_i  in  16  words to load; captured on start.
REQ-009 src_valid_i  in  1  source word valid.
REQ-010 src_data_i  in  32  source word, little-endian packed.
REQ-011 src_ready_o  out  1  loader accepts a source word.
REQ-012 core_en_i  in  1  core port-B request.
REQ-013 core_we_i  in  1  core write enable.
REQ-014 core_addr_i  in  ADDR_WIDTH  core byte address.
REQ-015 core_wdata_i  in  32  core write data.
REQ-016 core_be_i  in  4  core byte enables.
REQ-017 core_funct_i  in  FUNCT_WIDTH  core LiM function code.
REQ-018 core_rvalid_o  out  1  mem_rvalid_i forwarded to core.
REQ-019 mem_en_o, mem_we_o  out  1 each  port-B enable / write enable.
REQ-020 mem_addr_o  out  ADDR_WIDTH  port-B byte address.
REQ-021 mem_wdata_o  out  32  port-B write data.
REQ-022 mem_be_o  out  4  port-B byte enables.
REQ-023 mem_funct_o  out  FUNCT_WIDTH  port-B LiM function code.
REQ-024 mem_rvalid_i  in  1  port-B completion from racetrack memory.
REQ-025 busy_o, fetch_enable_o, error_o  out  1 each  loading / load complete (core may fetch) / timeout occurred.

Function
REQ-026 FSM states IDLE, FETCH, ISSUE, WAIT_RV, GAP, DONE, ERROR, registered.
REQ-027 IDLE: start_i=1 with num_words_i>0 -> FETCH, index=0; with num_words_i=0 -> DONE next cycle; start_i ignored in all other states.
REQ-028 FETCH: src_ready_o=1 (only here); src_valid_i&src_ready_o captures src_data_i -> ISSUE; else stay.
REQ-029 ISSUE: exactly one cycle mem_en_o=1, mem_we_o=1, mem_be_o=4'hF, mem_funct_o=0, mem_addr_o=base+4*index, mem_wdata_o=captured word -> WAIT_RV.
REQ-030 WAIT_RV: mem_en_o=0, address/data held; mem_rvalid_i=1 -> GAP; timeout counter reaching RV_TIMEOUT without rvalid -> ERROR.
REQ-031 GAP: one idle cycle, index+1; index+1==num_words -> DONE, else FETCH.
REQ-032 Address arithmetic modulo 2^ADDR_WIDTH; wrap-around permitted, not flagged.
REQ-033 busy_o=1 in FETCH, ISSUE, WAIT_RV, GAP.
REQ-034 Outside DONE, port B driven only by the loader (all mem_* 0 when not in ISSUE/WAIT_RV), core_rvalid_o=0, core requests dropped.
REQ-035 DONE: fetch_enable_o=1; all mem_* outputs combinationally equal corresponding core_* inputs; core_rvalid_o=mem_rvalid_i; held until reset.
REQ-036 ERROR: error_o=1, fetch_enable_o=0, port B idle, held until reset.
REQ-037 Latency per word with source always valid and rvalid N cycles after ISSUE: 3+N cycles.

Reset
REQ-038 rst_n low: state IDLE, index/timeout 0, all outputs 0 immediately, including mid-load; load restarts only by new start_i.

Verification
REQ-039 base=0x000, num=3, src always valid (0x11111111,0x22222222,0x33333333), rvalid 2 cycles after ISSUE -> writes to 0x0,0x4,0x8 with be=F, funct=0; fetch_enable_o rises 15 cycles after start.
REQ-040 num_words_i=0 -> DONE next cycle, fetch_enable_o=1, no mem_en_o pulse.
REQ-041 rvalid never returned -> error_o=1 exactly RV_TIMEOUT cycles after ISSUE, fetch_enable_o stays 0.
REQ-042 core_en_i=1 during load -> no core value on mem_*, core_rvalid_o=0; after DONE core_addr_i=0x40 appears on mem_addr_o same cycle.
REQ-043 base=2^22-4, num=2 -> second write at address 0x0.
REQ-044 rst_n low while in WAIT_RV -> outputs 0 asynchronously; src_valid gaps in FETCH stall without extra mem_en_o pulses.
